// File: rtl/lcd_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_arb_pkg
// Purpose  : Shared types and constants for the LCD command arbiter.
//            - state_t   : arbiter FSM state encoding
//            - CMD_W_DEF : default command width {rs, rw, data[7:0]}
//            - RS_BIT / RW_BIT : field positions inside a command word
// Revision : 1.0 - initial release
// ============================================================================
package lcd_arb_pkg;

  localparam int CMD_W_DEF = 10;
  localparam int RS_BIT    = 9;
  localparam int RW_BIT    = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

endpackage : lcd_arb_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin arbiter (priority pointer plus grant logic).
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            req[1:0]        - request vector
//            advance         - a grant is being taken this cycle
//            gnt_valid       - at least one request is pending
//            gnt_idx         - index of the requester that wins this cycle
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic r_ptr;

  // The pointer only breaks ties; a lone requester always wins.
  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) begin
      gnt_idx = r_ptr;
    end else begin
      gnt_idx = req[1];
    end
  end

  // After any grant the other requester gets priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (advance && gnt_valid) begin
      r_ptr <= ~gnt_idx;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/lcd_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lcd_cmd_arbiter
// Purpose  : Arbitrates two command requesters onto a single LCD controller
//            port, strobing each command once and tracking the LCD busy
//            handshake with a rise timeout.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            req0/cmd0/ack0      - requester 0 handshake
//            req1/cmd1/ack1      - requester 1 handshake
//            lcd_busy            - busy flag from the LCD controller
//            lcd_enable, lcd_bus - one-cycle command strobe and command
//            grant_id            - requester last granted
//            timeout_err         - sticky: busy never rose after an issue
//            idle                - FSM is in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module lcd_cmd_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CMD_W   = CMD_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [CMD_W-1:0] cmd0,
  output logic             ack0,
  input  logic             req1,
  input  logic [CMD_W-1:0] cmd1,
  output logic             ack1,
  input  logic             lcd_busy,
  output logic             lcd_enable,
  output logic [CMD_W-1:0] lcd_bus,
  output logic             grant_id,
  output logic             timeout_err,
  output logic             idle
);

  localparam int                 c_CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_TMO   = c_CNT_W'(TIMEOUT);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [c_CNT_W-1:0] w_cnt_inc;
  logic               w_tmo;
  logic               w_gnt_valid;
  logic               w_gnt_idx;
  logic               w_grant;
  logic [CMD_W-1:0]   r_hold;
  logic               r_enable;
  logic               r_ack0;
  logic               r_ack1;
  logic               r_grant_id;
  logic               r_err;
  logic               r_idle;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst       (rst),
    .req       ({req1, req0}),
    .advance   (w_grant),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  // A busy LCD (e.g. still initialising) blocks new grants entirely.
  assign w_grant   = (r_state == ST_IDLE) && !lcd_busy && w_gnt_valid;
  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tmo       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT_BUSY;
        w_cnt_nxt   = '0;
      end
      ST_WAIT_BUSY: begin
        if (lcd_busy) begin
          w_state_nxt = ST_WAIT_DONE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc == c_TMO) begin
          // The TIMEOUT-th cycle without busy gives up on this command.
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_tmo       = 1'b1;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      ST_WAIT_DONE: begin
        if (!lcd_busy) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Strobes are registered from the grant decision so they coincide with
  // the ISSUE state and carry no combinational glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_hold     <= '0;
      r_enable   <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_grant_id <= 1'b0;
      r_err      <= 1'b0;
      r_idle     <= 1'b1;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_enable <= w_grant;
      r_ack0   <= w_grant && !w_gnt_idx;
      r_ack1   <= w_grant &&  w_gnt_idx;
      r_idle   <= (w_state_nxt == ST_IDLE);
      if (w_grant) begin
        r_hold     <= w_gnt_idx ? cmd1 : cmd0;
        r_grant_id <= w_gnt_idx;
      end
      if (w_tmo) begin
        r_err <= 1'b1;
      end
    end
  end

  // r_enable is high exactly in ISSUE, so the bus is zero everywhere else.
  assign lcd_bus     = r_enable ? r_hold : '0;
  assign lcd_enable  = r_enable;
  assign ack0        = r_ack0;
  assign ack1        = r_ack1;
  assign grant_id    = r_grant_id;
  assign timeout_err = r_err;
  assign idle        = r_idle;

endmodule : lcd_cmd_arbiter
`default_nettype wire

// File: doc/lcd_cmd_arbiter.md
LCD_CMD_ARBITER -- requirements
Module: lcd_cmd_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16: maximum cycles to wait for lcd_busy to rise after issue.
REQ-002 The block SHALL have parameter CMD_W, default 10: command width, {rs, rw, data[7:0]}.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1: rising-edge clock.
REQ-005 The block SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-006 The block SHALL have port req0, input, 1: requester 0 has a command pending.
REQ-007 The block SHALL have port cmd0, input, CMD_W: requester 0 command, held stable while req0=1.
REQ-008 The block SHALL have port ack0, output, 1: one-cycle pulse, requester 0 command issued.
REQ-009 The block SHALL have ports req1, cmd1 and ack1, identical to the requester 0 ports, for requester 1.
REQ-010 The block SHALL have port lcd_busy, input, 1: busy flag from the LCD controller.
REQ-011 The block SHALL have port lcd_enable, output, 1: one-cycle command strobe to the LCD controller.
REQ-012 The block SHALL have port lcd_bus, output, CMD_W: command to the LCD controller, valid while lcd_enable=1.
REQ-013 The block SHALL have port grant_id, output, 1: index of the requester last granted.
REQ-014 The block SHALL have port timeout_err, output, 1: sticky error flag, set when lcd_busy fails to rise in time.
REQ-015 The block SHALL have port idle, output, 1: high when the FSM is in IDLE.

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-017 In IDLE with lcd_busy=0 and any req high, the block SHALL grant one requester at the clock edge and enter ISSUE; with lcd_busy=1 (LCD power-up/init) it SHALL grant nothing.
REQ-018 Arbitration SHALL be round-robin: with both reqs high, grant the requester matching the priority pointer; after any grant, the pointer moves to the other requester.
REQ-019 On a grant, the block SHALL latch the granted cmd into a holding register; lcd_bus SHALL drive the holding register and be 0 outside ISSUE.
REQ-020 In ISSUE, lcd_enable=1 and ack of the granted requester=1 for exactly one cycle, then WAIT_BUSY; first-cycle latency from req sampled in IDLE to lcd_enable is 1 cycle.
REQ-021 WAIT_BUSY SHALL increment a counter (width clog2(TIMEOUT+1)) each cycle; lcd_busy=1 -> WAIT_DONE and clear the counter.
REQ-022 If the counter reaches TIMEOUT in WAIT_BUSY, the block SHALL set timeout_err, clear the counter and return to IDLE.
REQ-023 WAIT_DONE SHALL remain until lcd_busy=0, then return to IDLE; there is no timeout in WAIT_DONE.
REQ-024 A requester SHALL see ack only for its own command; req dropped before ack cancels the request without side effects.
REQ-025 The same requester re-requesting in the cycle after ack SHALL be served only after the other requester if that requester is pending.
REQ-026 lcd_enable, ack0, ack1 and idle SHALL be registered outputs, glitch-free.

Reset
REQ-027 rst=1 SHALL force, asynchronously: state=IDLE, lcd_enable=0, lcd_bus=0, ack0=ack1=0, grant_id=0, timeout_err=0, counter=0, pointer=requester 0, idle=1.
REQ-028 Reset mid-transaction SHALL abort without ack; a request held through reset SHALL be re-arbitrated after release.

Structure
REQ-029 Package lcd_arb_pkg SHALL hold the state enum, CMD_W default and the field-position constants RS_BIT=9, RW_BIT=8.
REQ-030 A sub-module rr_arb2 (2-way round-robin, pointer plus grant logic) SHALL be instantiated; the FSM, counter and holding register SHALL remain in lcd_cmd_arbiter.

Verification
REQ-031 The bench SHALL cover: req0=1, cmd0=0x238, lcd_busy low -> lcd_enable=1 and lcd_bus=0x238 one cycle later, with ack0 pulsing once.
REQ-032 The bench SHALL cover: req0=req1=1 held for 4 transactions, with lcd_busy modelled high for 3 cycles per command -> grant order 0,1,0,1.
REQ-033 The bench SHALL cover: lcd_busy held high for 100 cycles (init) with req1=1 -> no lcd_enable until lcd_busy falls.
REQ-034 The bench SHALL cover: issue with lcd_busy never rising, TIMEOUT=16 -> timeout_err=1 after 16 WAIT_BUSY cycles and idle=1; the next request is still served.
REQ-035 The bench SHALL cover: rst asserted during WAIT_DONE -> all outputs at reset values immediately, with no ack.
REQ-036 The bench SHALL cover: req1 dropped before grant while req0 pending -> only ack0 pulses and cmd1 never appears on lcd_bus.
